// File: rtl/mask_bbox_rx.sv
// Bounding-box / pixel-count accumulator for a binary mask stream; results are handed off via a valid/ready pair.
// Optional feature: define MASK_BBOX_PIXCOUNT_EN to accumulate pix_count (otherwise it is tied to 0).
module mask_bbox_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int LAT        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic [DATA_WIDTH-1:0] mask_in,
  input  logic                  res_ready,
  output logic                  res_valid,
  output logic                  found,
  output logic [15:0]           x_min,
  output logic [15:0]           x_max,
  output logic [15:0]           y_min,
  output logic [15:0]           y_max,
  output logic [31:0]           pix_count,
  output logic                  overrun,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  state_t          state_q, state_d;
  logic [LAT-1:0]  dv_q, dv_d, ds_q, ds_d;
  logic [15:0]     x_q, x_d, y_q, y_d;
  logic            acc_found_q, acc_found_d;
  logic [15:0]     acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [15:0]     acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic            res_valid_q, res_valid_d, found_q, found_d;
  logic [15:0]     xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic            overrun_q, overrun_d;
`ifdef MASK_BBOX_PIXCOUNT_EN
  logic [31:0]     acc_cnt_q, acc_cnt_d, cnt_q, cnt_d, n_cnt;
`endif

  logic            a_valid, a_sof, det, take, restart, last;
  logic [15:0]     cur_x, cur_y, n_xmin, n_xmax, n_ymin, n_ymax;
  logic            n_found;
  logic            unused_mask_bits;

  assign a_valid          = dv_q[LAT-1];
  assign a_sof            = ds_q[LAT-1];
  assign det              = a_valid & mask_in[DATA_WIDTH-1];
  assign unused_mask_bits = ^mask_in;

  always_comb begin
    dv_d        = LAT'({dv_q, pix_valid});
    ds_d        = LAT'({ds_q, pix_sof});
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_found_d = acc_found_q;
    acc_xmin_d  = acc_xmin_q;
    acc_xmax_d  = acc_xmax_q;
    acc_ymin_d  = acc_ymin_q;
    acc_ymax_d  = acc_ymax_q;
    res_valid_d = res_valid_q;
    found_d     = found_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    overrun_d   = overrun_q;
    take        = 1'b0;
    restart     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (a_valid && a_sof) begin
          take    = 1'b1;
          restart = 1'b1;
        end
      end
      ACTIVE: begin
        if (a_valid) begin
          take    = 1'b1;
          restart = a_sof;
        end
      end
      DONE: begin
        // A frame starting while the result is still pending is lost.
        if (a_valid && a_sof) overrun_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame start processes its own pixel as (0,0) against cleared accumulators.
    cur_x   = restart ? '0 : x_q;
    cur_y   = restart ? '0 : y_q;
    n_found = restart ? 1'b0 : acc_found_q;
    n_xmin  = restart ? '0 : acc_xmin_q;
    n_xmax  = restart ? '0 : acc_xmax_q;
    n_ymin  = restart ? '0 : acc_ymin_q;
    n_ymax  = restart ? '0 : acc_ymax_q;
`ifdef MASK_BBOX_PIXCOUNT_EN
    n_cnt   = restart ? '0 : acc_cnt_q;
`endif
    if (det) begin
      if (!n_found) begin
        n_xmin = cur_x;
        n_xmax = cur_x;
        n_ymin = cur_y;
        n_ymax = cur_y;
      end else begin
        if (cur_x < n_xmin) n_xmin = cur_x;
        if (cur_x > n_xmax) n_xmax = cur_x;
        if (cur_y < n_ymin) n_ymin = cur_y;
        if (cur_y > n_ymax) n_ymax = cur_y;
      end
      n_found = 1'b1;
`ifdef MASK_BBOX_PIXCOUNT_EN
      n_cnt   = n_cnt + 32'd1;
`endif
    end
    last = (cur_x == X_LAST) && (cur_y == Y_LAST);

`ifdef MASK_BBOX_PIXCOUNT_EN
    acc_cnt_d = acc_cnt_q;
    cnt_d     = cnt_q;
`endif
    if (take) begin
      acc_found_d = n_found;
      acc_xmin_d  = n_xmin;
      acc_xmax_d  = n_xmax;
      acc_ymin_d  = n_ymin;
      acc_ymax_d  = n_ymax;
`ifdef MASK_BBOX_PIXCOUNT_EN
      acc_cnt_d   = n_cnt;
`endif
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = cur_y + 16'd1;
      end else begin
        x_d = cur_x + 16'd1;
        y_d = cur_y;
      end
      if (last) begin
        found_d     = n_found;
        xmin_d      = n_xmin;
        xmax_d      = n_xmax;
        ymin_d      = n_ymin;
        ymax_d      = n_ymax;
`ifdef MASK_BBOX_PIXCOUNT_EN
        cnt_d       = n_cnt;
`endif
        res_valid_d = 1'b1;
        state_d     = DONE;
      end else begin
        state_d     = ACTIVE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dv_q        <= '0;
      ds_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      acc_found_q <= 1'b0;
      acc_xmin_q  <= '0;
      acc_xmax_q  <= '0;
      acc_ymin_q  <= '0;
      acc_ymax_q  <= '0;
      res_valid_q <= 1'b0;
      found_q     <= 1'b0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      overrun_q   <= 1'b0;
`ifdef MASK_BBOX_PIXCOUNT_EN
      acc_cnt_q   <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dv_q        <= dv_d;
      ds_q        <= ds_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_found_q <= acc_found_d;
      acc_xmin_q  <= acc_xmin_d;
      acc_xmax_q  <= acc_xmax_d;
      acc_ymin_q  <= acc_ymin_d;
      acc_ymax_q  <= acc_ymax_d;
      res_valid_q <= res_valid_d;
      found_q     <= found_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      overrun_q   <= overrun_d;
`ifdef MASK_BBOX_PIXCOUNT_EN
      acc_cnt_q   <= acc_cnt_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign found     = found_q;
  assign x_min     = xmin_q;
  assign x_max     = xmax_q;
  assign y_min     = ymin_q;
  assign y_max     = ymax_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == ACTIVE);
`ifdef MASK_BBOX_PIXCOUNT_EN
  assign pix_count = cnt_q;
`else
  assign pix_count = '0;
`endif

endmodule

// File: tb/tb_mask_bbox_rx.sv
// Self-checking bench for mask_bbox_rx: directed frame table, corner sequences, and random traffic vs a frame-level model.
module tb_mask_bbox_rx;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int LAT = 3;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst, pix_valid, pix_sof, res_ready;
  logic [DW-1:0] mask_in;
  logic          res_valid, found, overrun, busy;
  logic [15:0]   x_min, x_max, y_min, y_max;
  logic [31:0]   pix_count;

  always #5 clk = ~clk;

  mask_bbox_rx #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .mask_in(mask_in),
    .res_ready(res_ready), .res_valid(res_valid), .found(found), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .pix_count(pix_count), .overrun(overrun), .busy(busy)
  );

  int vecs = 0;
  int miscompares = 0;

  // Stimulus history: index LAT-1 is the pixel whose mask is due at mask_in now.
  bit hv[LAT], hs[LAT], hd[LAT];

  // Frame-level model: linear pixel index plus a list of detected coordinates.
  int mode = 0;  // 0 waiting for frame, 1 in frame, 2 result pending
  int n = 0;
  int qx[$], qy[$];
  bit m_rv = 0, m_ovr = 0, m_found = 0;
  int m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0, m_cnt = 0;

  bit got;
  bit g_found;
  int g_xmin, g_xmax, g_ymin, g_ymax, g_cnt;

  function automatic void model_reset();
    mode = 0; n = 0; qx.delete(); qy.delete();
    m_rv = 0; m_ovr = 0; m_found = 0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_cnt = 0;
  endfunction

  function automatic void take_pixel(bit ad);
    if (ad) begin qx.push_back(n % W); qy.push_back(n / W); end
    if (n == W * H - 1) begin
      m_found = qx.size() > 0;
      m_cnt = qx.size();
      m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
      foreach (qx[i]) begin
        if (i == 0 || qx[i] < m_xmin) m_xmin = qx[i];
        if (i == 0 || qx[i] > m_xmax) m_xmax = qx[i];
        if (i == 0 || qy[i] < m_ymin) m_ymin = qy[i];
        if (i == 0 || qy[i] > m_ymax) m_ymax = qy[i];
      end
      m_rv = 1; mode = 2;
    end else begin
      n++; mode = 1;
    end
  endfunction

  function automatic void model_cycle(bit r, bit av, bit as, bit ad, bit rr);
    if (r) begin model_reset(); return; end
    case (mode)
      0: if (av && as) begin qx.delete(); qy.delete(); n = 0; take_pixel(ad); end
      1: if (av) begin
           if (as) begin qx.delete(); qy.delete(); n = 0; end
           take_pixel(ad);
         end
      default: begin
        if (av && as) m_ovr = 1;
        if (rr) begin m_rv = 0; mode = 0; end
      end
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit pv, input bit ps, input bit pd);
    bit av, as, ad;
    logic [99:0] e, a;
    av = hv[LAT-1]; as = hs[LAT-1]; ad = hd[LAT-1];
    rst = r; pix_valid = pv; pix_sof = ps;
    mask_in = {(av ? ad : 1'($urandom)), 7'($urandom)};
    model_cycle(r, av, as, ad, res_ready);
    for (int i = LAT - 1; i > 0; i--) begin
      hv[i] = r ? 1'b0 : hv[i-1]; hs[i] = r ? 1'b0 : hs[i-1]; hd[i] = r ? 1'b0 : hd[i-1];
    end
    hv[0] = r ? 1'b0 : pv; hs[0] = r ? 1'b0 : ps; hd[0] = r ? 1'b0 : pd;
    @(posedge clk);
    @(negedge clk);
`ifdef MASK_BBOX_PIXCOUNT_EN
    e = {m_rv, (mode == 1), m_ovr, m_found, 16'(m_xmin), 16'(m_xmax), 16'(m_ymin), 16'(m_ymax), 32'(m_cnt)};
`else
    e = {m_rv, (mode == 1), m_ovr, m_found, 16'(m_xmin), 16'(m_xmax), 16'(m_ymin), 16'(m_ymax), 32'd0};
`endif
    a = {res_valid, busy, overrun, found, x_min, x_max, y_min, y_max, pix_count};
    vecs++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got %h, expected %h (rv,busy,ovr,found,xmin,xmax,ymin,ymax,cnt)", $time, a, e);
    end
    if (res_valid === 1'b1 && !got) begin
      got = 1; g_found = found; g_xmin = x_min; g_xmax = x_max;
      g_ymin = y_min; g_ymax = y_max; g_cnt = pix_count;
    end
  endtask

  // Full frame with up to two detections (negative coordinate = unused); toggle inserts a gap after each pixel.
  task automatic run_frame(input int ax, input int ay, input int bx, input int by, input bit toggle);
    for (int p = 0; p < W * H; p++) begin
      step(0, 1, p == 0, ((p % W) == ax && (p / W) == ay) || ((p % W) == bx && (p / W) == by));
      if (toggle) step(0, 0, 1'($urandom), 1'($urandom));
    end
    for (int k = 0; k < LAT + 2; k++) step(0, 0, 1'($urandom), 0);
  endtask

  task automatic check_result(input string nm, input bit f, input int x0, input int x1,
                              input int y0, input int y1, input int c);
    chk({nm, ".seen"}, got, 1);
    chk({nm, ".found"}, g_found, f);
    chk({nm, ".x_min"}, g_xmin, x0);
    chk({nm, ".x_max"}, g_xmax, x1);
    chk({nm, ".y_min"}, g_ymin, y0);
    chk({nm, ".y_max"}, g_ymax, y1);
`ifdef MASK_BBOX_PIXCOUNT_EN
    chk({nm, ".pix_count"}, g_cnt, c);
`else
    chk({nm, ".pix_count"}, g_cnt, 0);
    if (c < 0) $display("note: negative count %0d", c);
`endif
  endtask

  typedef struct {
    int ax, ay, bx, by;
    bit toggle;
    bit e_found;
    int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int g;
    bit r, pv, ps, d;

    tbl[0] = '{ax: 2, ay: 1, bx: 5, by: 3, toggle: 0, e_found: 1, e_xmin: 2, e_xmax: 5, e_ymin: 1, e_ymax: 3, e_cnt: 2};
    tbl[1] = '{ax: -1, ay: -1, bx: -1, by: -1, toggle: 0, e_found: 0, e_xmin: 0, e_xmax: 0, e_ymin: 0, e_ymax: 0, e_cnt: 0};
    tbl[2] = '{ax: 7, ay: 0, bx: -1, by: -1, toggle: 1, e_found: 1, e_xmin: 7, e_xmax: 7, e_ymin: 0, e_ymax: 0, e_cnt: 1};
    tbl[3] = '{ax: 6, ay: 3, bx: 1, by: 2, toggle: 1, e_found: 1, e_xmin: 1, e_xmax: 6, e_ymin: 2, e_ymax: 3, e_cnt: 2};

    rst = 1; pix_valid = 0; pix_sof = 0; mask_in = '0; res_ready = 1; got = 0;
    foreach (hv[i]) begin hv[i] = 0; hs[i] = 0; hd[i] = 0; end
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(1, 1, 1, 1);
    chk("reset.res_valid", res_valid, 0);
    chk("reset.busy", busy, 0);
    chk("reset.x_max", x_max, 0);

    for (int i = 0; i < 4; i++) begin
      got = 0;
      run_frame(tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].toggle);
      check_result($sformatf("table%0d", i), tbl[i].e_found, tbl[i].e_xmin, tbl[i].e_xmax,
                   tbl[i].e_ymin, tbl[i].e_ymax, tbl[i].e_cnt);
    end

    // Result held while the next frame's start arrives.
    res_ready = 0; got = 0;
    run_frame(1, 1, -1, -1, 0);
    run_frame(4, 2, -1, -1, 0);
    chk("hold.res_valid", res_valid, 1);
    chk("hold.overrun", overrun, 1);
    chk("hold.x_min", x_min, 1);
    chk("hold.busy", busy, 0);
    res_ready = 1;
    step(0, 0, 0, 0);
    chk("hold.released", res_valid, 0);
    got = 0;
    run_frame(3, 2, -1, -1, 0);
    check_result("after_overrun", 1, 3, 3, 2, 2, 1);
    chk("after_overrun.sticky", overrun, 1);

    // Restart at pixel 10: the aborted frame's detection must not leak.
    got = 0;
    for (int p = 0; p < 10; p++) step(0, 1, p == 0, p == 3);
    run_frame(6, 2, -1, -1, 0);
    check_result("restart", 1, 6, 6, 2, 2, 1);

    // Reset mid-frame, then a frame detecting only the origin.
    for (int p = 0; p < 12; p++) step(0, 1, p == 0, 1);
    for (int k = 0; k < 3; k++) step(1, 1, 1'($urandom), 1);
    chk("midreset.overrun", overrun, 0);
    chk("midreset.found", found, 0);
    got = 0;
    run_frame(0, 0, -1, -1, 0);
    check_result("origin", 1, 0, 0, 0, 0, 1);

    // Random traffic against the model.
    g = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom % 600) == 0;
      res_ready = ($urandom % 4) != 0;
      pv = ($urandom % 4) != 0;
      if (pv && ($urandom % 300) == 0) g = 0;
      ps = pv ? (g == 0) : 1'($urandom);
      d = ($urandom % 5) == 0;
      step(r, pv, ps, d);
      if (r) g = 0;
      else if (pv) g = (g + 1) % (W * H);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
